// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl
// Command-driven sequencer for a bidirectional serial shift register.
// It accepts a transfer command, drives sh/rt/y for exactly n cycles,
// gathers the bits that leave through q_out, and returns them as a
// response word.
// Optional feature: define SHIFT_SEQ_ROTATE_EN to honour cmd_rot. With
// cmd_rot set, the serial input is fed from q_out so the register rotates.
module shift_seq_ctrl #(
  parameter int W  = 5,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rt,
  input  logic [CW-1:0] cmd_cnt,
  input  logic [W-1:0]  cmd_data,
  input  logic          cmd_rot,
  output logic          sh,
  output logic          rt,
  output logic          y,
  input  logic          q_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic          rt_q;
  logic [W-1:0]  data_q;
  logic [CW-1:0] n_q;
  logic [CW-1:0] k_q;
  logic [W-1:0]  rsp_q;
  logic [CW-1:0] cnt_clamp;
  logic          last_step;
  logic          y_src;

`ifdef SHIFT_SEQ_ROTATE_EN
  logic          rot_q;
`else
  // Without the rotate feature the request bit has no consumer.
  logic          unused_cmd_rot;
  assign unused_cmd_rot = cmd_rot;
`endif

  // Oversized counts saturate at the register width; no error is raised.
  assign cnt_clamp = (cmd_cnt > CW'(W)) ? CW'(W) : cmd_cnt;

  // The step being performed this cycle is the final one of the command.
  assign last_step = (k_q == (n_q - CW'(1)));

  // State register; reset drops any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: no IDLE bypass, so every command passes through RESP.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cnt_clamp == '0) ? RESP : SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Command latch, step index and result capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rt_q   <= 1'b0;
      data_q <= '0;
      n_q    <= '0;
      k_q    <= '0;
      rsp_q  <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            rt_q   <= cmd_rt;
            data_q <= cmd_data;
            n_q    <= cnt_clamp;
            k_q    <= '0;
            rsp_q  <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q  <= cmd_rot;
`endif
          end
        end
        SHIFT: begin
          rsp_q[k_q] <= q_out;
          k_q        <= k_q + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Serial input source: the fill bit for this step, or the bit leaving
  // the register when rotating.
  always_comb begin
    y_src = data_q[k_q];
`ifdef SHIFT_SEQ_ROTATE_EN
    if (rot_q) begin
      y_src = q_out;
    end
`endif
  end

  // Outputs are decoded from state or taken straight from registers.
  always_comb begin
    cmd_ready = 1'b0;
    sh        = 1'b0;
    rsp_valid = 1'b0;
    busy      = 1'b1;
    y         = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      SHIFT: begin
        sh = 1'b1;
        y  = y_src;
      end
      RESP: begin
        rsp_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign rt       = rt_q;
  assign rsp_data = rsp_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl
// Directed bench for shift_seq_ctrl with a 5-bit shift register model
// attached to sh/rt/y/q_out. Define SHIFT_SEQ_ROTATE_EN for the rotate build.
module tb_shift_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rt;
  logic [2:0] cmd_cnt;
  logic [4:0] cmd_data;
  logic       cmd_rot;
  logic       sh;
  logic       rt;
  logic       y;
  logic       q_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [4:0] rsp_data;
  logic       busy;

  logic [4:0] sreg;
  logic [4:0] preload_val;
  logic       preload_en;

  int checks;
  int errors;

  typedef struct {
    logic [4:0] preload;
    logic       rt;
    logic [2:0] cnt;
    logic [4:0] data;
    logic       rot;
    logic [4:0] exp_rsp;
    logic [4:0] exp_reg;
    int         exp_shifts;
  } vec_t;

  vec_t vecs [7];

  shift_seq_ctrl #(.W(5), .CW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rt    (cmd_rt),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .cmd_rot   (cmd_rot),
    .sh        (sh),
    .rt        (rt),
    .y         (y),
    .q_out     (q_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shift register model: right moves toward bit 0 with y entering at bit 4.
  always @(posedge clk) begin
    if (preload_en) begin
      sreg <= preload_val;
    end else if (sh) begin
      sreg <= rt ? {y, sreg[4:1]} : {sreg[3:0], y};
    end
  end

  assign q_out = rt ? sreg[0] : sreg[4];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic preload(input logic [4:0] val);
    @(negedge clk);
    preload_val = val;
    preload_en  = 1'b1;
    @(posedge clk);
    #1;
    preload_en  = 1'b0;
  endtask

  task automatic waitResp(output int cycles, output int shifts);
    cycles = 0;
    shifts = 0;
    while (!rsp_valid && cycles < 20) begin
      if (sh) shifts++;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int cycles;
    int shifts;
    preload(v.preload);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rt    = v.rt;
    cmd_cnt   = v.cnt;
    cmd_data  = v.data;
    cmd_rot   = v.rot;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    checkOutput($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd0);
    waitResp(cycles, shifts);
    checkOutput($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
    checkOutput($sformatf("v%0d_latency", idx), 32'(cycles), 32'(v.exp_shifts));
    checkOutput($sformatf("v%0d_shifts", idx), 32'(shifts), 32'(v.exp_shifts));
    checkOutput($sformatf("v%0d_rsp_data", idx), 32'(rsp_data), 32'(v.exp_rsp));
    checkOutput($sformatf("v%0d_sreg", idx), 32'(sreg), 32'(v.exp_reg));
    checkOutput($sformatf("v%0d_resp_sh", idx), 32'(sh), 32'd0);
    checkOutput($sformatf("v%0d_resp_y", idx), 32'(y), 32'd0);
    checkOutput($sformatf("v%0d_resp_rt", idx), 32'(rt), 32'(v.rt));
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput($sformatf("v%0d_rsp_drop", idx), 32'(rsp_valid), 32'd0);
    checkOutput($sformatf("v%0d_idle_ready", idx), 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    int cycles;
    int shifts;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    cmd_valid   = 1'b0;
    cmd_rt      = 1'b0;
    cmd_cnt     = 3'd0;
    cmd_data    = 5'd0;
    cmd_rot     = 1'b0;
    rsp_ready   = 1'b0;
    preload_en  = 1'b0;
    preload_val = 5'd0;

    //               preload   rt   cnt   data      rot   rsp       reg       n
    vecs[0] = '{5'b10110, 1'b1, 3'd5, 5'b01101, 1'b0, 5'b10110, 5'b01101, 5};
    vecs[1] = '{5'b10110, 1'b0, 3'd2, 5'b00011, 1'b0, 5'b00001, 5'b11011, 2};
    vecs[2] = '{5'b10110, 1'b1, 3'd0, 5'b11111, 1'b0, 5'b00000, 5'b10110, 0};
    vecs[3] = '{5'b10110, 1'b0, 3'd7, 5'b00000, 1'b0, 5'b01101, 5'b00000, 5};
    vecs[4] = '{5'b01001, 1'b1, 3'd3, 5'b00101, 1'b0, 5'b00001, 5'b10101, 3};
    vecs[5] = '{5'b11100, 1'b0, 3'd4, 5'b01010, 1'b0, 5'b00111, 5'b00101, 4};
`ifdef SHIFT_SEQ_ROTATE_EN
    vecs[6] = '{5'b10110, 1'b1, 3'd5, 5'b01101, 1'b1, 5'b10110, 5'b10110, 5};
`else
    vecs[6] = '{5'b10110, 1'b1, 3'd5, 5'b01101, 1'b1, 5'b10110, 5'b01101, 5};
`endif

    // Reset values, with a command offered while reset is held.
    #12;
    cmd_valid = 1'b1;
    cmd_cnt   = 3'd3;
    @(posedge clk);
    #1;
    checkOutput("rst_sh", 32'(sh), 32'd0);
    checkOutput("rst_rt", 32'(rt), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_cnt   = 3'd0;
    rst       = 1'b0;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Response back-pressure with a second command waiting.
    preload(5'b10110);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rt    = 1'b1;
    cmd_cnt   = 3'd2;
    cmd_data  = 5'b00000;
    cmd_rot   = 1'b0;
    @(posedge clk);
    #1;
    cmd_cnt   = 3'd1;
    waitResp(cycles, shifts);
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold%0d_valid", c), 32'(rsp_valid), 32'd1);
      checkOutput($sformatf("bp_hold%0d_data", c), 32'(rsp_data), 32'b00010);
      checkOutput($sformatf("bp_hold%0d_ready", c), 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("bp_release_valid", 32'(rsp_valid), 32'd0);
    checkOutput("bp_release_busy", 32'(busy), 32'd0);
    checkOutput("bp_release_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkOutput("bp_second_accept", 32'(busy), 32'd1);
    waitResp(cycles, shifts);
    checkOutput("bp_second_shifts", 32'(shifts), 32'd1);
    checkOutput("bp_second_rsp", 32'(rsp_data), 32'b00001);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Reset pulsed during step 2 of a five-step command.
    preload(5'b10110);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_rt    = 1'b1;
    cmd_cnt   = 3'd5;
    cmd_data  = 5'b11111;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checkOutput("mid_pre_rsp_data", 32'(rsp_data), 32'b00010);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_sh", 32'(sh), 32'd0);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(vecs[1], 100);

    // rsp_ready held high ahead of the response: one-cycle response.
    preload(5'b10000);
    @(negedge clk);
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_rt    = 1'b0;
    cmd_cnt   = 3'd1;
    cmd_data  = 5'b00001;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    waitResp(cycles, shifts);
    checkOutput("early_rsp_valid", 32'(rsp_valid), 32'd1);
    checkOutput("early_rsp_data", 32'(rsp_data), 32'b00001);
    @(posedge clk);
    #1;
    checkOutput("early_one_cycle", 32'(rsp_valid), 32'd0);
    checkOutput("early_sreg", 32'(sreg), 32'b00001);
    rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
